// File: rtl/rsa_pkg.sv
// Shared definitions for the modular-exponentiation scheduler: state encoding,
// default operand width and the default engine watchdog budget.
package rsa_pkg;

    localparam int DEF_WORDSIZE       = 16;
    // Engine spends this many cycles per exponent bit (square + multiply).
    localparam int ENG_CYCLES_PER_BIT = 32;
    localparam int DEF_TIMEOUT_CYCLES = 2 * DEF_WORDSIZE * ENG_CYCLES_PER_BIT;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

endpackage

// File: rtl/modexp_scheduler_if.sv
// Requester-side bundle of the scheduler: job request handshake with flattened
// operands and the response handshake on a shared result bus.
interface modexp_scheduler_if #(
    parameter int NUM_REQ = 2,
    parameter int W2      = 32
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*W2-1:0] req_base;
    logic [NUM_REQ*W2-1:0] req_modulo;
    logic [NUM_REQ*W2-1:0] req_exponent;
    logic [NUM_REQ-1:0]    resp_valid;
    logic [NUM_REQ-1:0]    resp_ready;
    logic [W2-1:0]         resp_result;
    logic                  resp_err;

    modport master (
        output req_valid, req_base, req_modulo, req_exponent, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_err
    );

    modport slave (
        input  req_valid, req_base, req_modulo, req_exponent, resp_ready,
        output req_ready, resp_valid, resp_result, resp_err
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester after last_grant, wrapping.
module rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      grant_idx,
    output logic               grant_valid
);

    // Scan from last_grant+1 so the previous winner is considered last.
    always_comb begin
        int idx;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (!grant_valid && req[IW'(idx)]) begin
                grant_valid = 1'b1;
                grant_idx   = IW'(idx);
            end else begin
                grant_valid = grant_valid;
            end
        end
        if (grant_valid) begin
            grant = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx;
        end else begin
            grant = '0;
        end
    end

endmodule

// File: rtl/modexp_scheduler.sv
// Shares one modexp engine between NUM_REQ requesters: round-robin accept,
// operand latch, load/run/finish sequencing with watchdog, and result return.
module modexp_scheduler
    import rsa_pkg::*;
#(
    parameter  int WORDSIZE       = DEF_WORDSIZE,
    parameter  int NUM_REQ        = 2,
    parameter  int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int W2             = 2 * WORDSIZE,
    localparam int IW             = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int TW             = $clog2(TIMEOUT_CYCLES) + 1
) (
    input  logic                clk,
    input  logic                reset_n,
    modexp_scheduler_if.slave   rq,
    output logic                busy,
    output logic                eng_load,
    output logic [W2-1:0]       eng_base,
    output logic [W2-1:0]       eng_modulo,
    output logic [W2-1:0]       eng_exponent,
    input  logic                eng_finish,
    input  logic [W2-1:0]       eng_result
);

    logic [1:0]         state_q, state_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic [IW-1:0]      last_grant_q, last_grant_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [W2-1:0]      base_q, base_d, modulo_q, modulo_d, exponent_q, exponent_d;
    logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
    logic [W2-1:0]      resp_result_q, resp_result_d;
    logic               resp_err_q, resp_err_d;
    logic               eng_load_q, eng_load_d;
    logic               busy_q, busy_d;

    logic [NUM_REQ-1:0] grant_s;
    logic [IW-1:0]      grant_idx_s;
    logic               grant_valid_s;
    logic [W2-1:0]      sel_base_s, sel_modulo_s, sel_exponent_s;
    logic [NUM_REQ-1:0] owner_hot_s;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req         (rq.req_valid),
        .last_grant  (last_grant_q),
        .grant       (grant_s),
        .grant_idx   (grant_idx_s),
        .grant_valid (grant_valid_s)
    );

    // Operand mux for the winning requester.
    always_comb begin
        sel_base_s     = '0;
        sel_modulo_s   = '0;
        sel_exponent_s = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_idx_s == IW'(k)) begin
                sel_base_s     = rq.req_base[k*W2 +: W2];
                sel_modulo_s   = rq.req_modulo[k*W2 +: W2];
                sel_exponent_s = rq.req_exponent[k*W2 +: W2];
            end else begin
                sel_base_s     = sel_base_s;
            end
        end
    end

    assign owner_hot_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;

    // Next-state logic for the job sequencer.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_grant_d  = last_grant_q;
        timer_d       = timer_q;
        base_d        = base_q;
        modulo_d      = modulo_q;
        exponent_d    = exponent_q;
        req_ready_d   = '0;
        resp_valid_d  = resp_valid_q;
        resp_result_d = resp_result_q;
        resp_err_d    = resp_err_q;
        eng_load_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid_s) begin
                    req_ready_d = grant_s;
                    owner_d     = grant_idx_s;
                    if (sel_modulo_s == '0) begin
                        // Zero modulus is answered directly; the engine never sees it.
                        resp_err_d    = 1'b1;
                        resp_result_d = '0;
                        resp_valid_d  = grant_s;
                        state_d       = ST_RESP;
                    end else begin
                        base_d     = sel_base_s;
                        modulo_d   = sel_modulo_s;
                        exponent_d = sel_exponent_s;
                        eng_load_d = 1'b1;
                        state_d    = ST_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                timer_d = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                timer_d = timer_q + TW'(1);
                if (eng_finish) begin
                    resp_result_d = eng_result;
                    resp_err_d    = 1'b0;
                    resp_valid_d  = owner_hot_s;
                    state_d       = ST_RESP;
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    // Abandon the job; the next LOAD reinitialises the engine.
                    resp_result_d = '0;
                    resp_err_d    = 1'b1;
                    resp_valid_d  = owner_hot_s;
                    state_d       = ST_RESP;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RESP: begin
                if (rq.resp_ready[owner_q]) begin
                    resp_valid_d = '0;
                    last_grant_d = owner_q;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                resp_valid_d = '0;
                state_d      = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            owner_q       <= '0;
            last_grant_q  <= IW'(NUM_REQ - 1);
            timer_q       <= '0;
            base_q        <= '0;
            modulo_q      <= '0;
            exponent_q    <= '0;
            req_ready_q   <= '0;
            resp_valid_q  <= '0;
            resp_result_q <= '0;
            resp_err_q    <= 1'b0;
            eng_load_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_grant_q  <= last_grant_d;
            timer_q       <= timer_d;
            base_q        <= base_d;
            modulo_q      <= modulo_d;
            exponent_q    <= exponent_d;
            req_ready_q   <= req_ready_d;
            resp_valid_q  <= resp_valid_d;
            resp_result_q <= resp_result_d;
            resp_err_q    <= resp_err_d;
            eng_load_q    <= eng_load_d;
            busy_q        <= busy_d;
        end
    end

    assign rq.req_ready   = req_ready_q;
    assign rq.resp_valid  = resp_valid_q;
    assign rq.resp_result = resp_result_q;
    assign rq.resp_err    = resp_err_q;
    assign busy           = busy_q;
    assign eng_load       = eng_load_q;
    assign eng_base       = base_q;
    assign eng_modulo     = modulo_q;
    assign eng_exponent   = exponent_q;

endmodule

// File: tb/tb_modexp_scheduler.sv
// Scoreboard bench for modexp_scheduler with a behavioural modexp engine that
// can be made to hang or emit a stray finish pulse.
module tb_modexp_scheduler;

    localparam int W2      = 32;
    localparam int NREQ    = 2;
    localparam int TMO     = 64;
    localparam int ENG_LAT = 20;

    typedef struct packed {
        logic [1:0]    id;
        logic [W2-1:0] result;
        logic          err;
    } exp_t;

    logic          clk;
    logic          reset_n;
    logic          busy;
    logic          eng_load;
    logic [W2-1:0] eng_base, eng_modulo, eng_exponent;
    logic          eng_finish;
    logic [W2-1:0] eng_result;

    modexp_scheduler_if #(.NUM_REQ(NREQ), .W2(W2)) rq ();

    modexp_scheduler #(.WORDSIZE(16), .NUM_REQ(NREQ), .TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rq           (rq),
        .busy         (busy),
        .eng_load     (eng_load),
        .eng_base     (eng_base),
        .eng_modulo   (eng_modulo),
        .eng_exponent (eng_exponent),
        .eng_finish   (eng_finish),
        .eng_result   (eng_result)
    );

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    logic [NREQ-1:0] pending = '0;
    logic [W2-1:0]   op_base[NREQ], op_mod[NREQ], op_exp[NREQ];
    int              rr_cnt[NREQ];
    int              load_cnt = 0;
    logic            auto_ack = 1'b1;
    logic [NREQ-1:0] man_ready = '0;
    logic            hang = 1'b0;
    logic            inject_finish = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, expv);
        end
    endtask

    function automatic logic [W2-1:0] ref_modexp(input logic [W2-1:0] b, input logic [W2-1:0] e,
                                                  input logic [W2-1:0] m);
        longint unsigned r, x, mm;
        mm = longint'(m);
        r  = 1 % mm;
        x  = longint'(b) % mm;
        for (int i = 0; i < W2; i++) begin
            if (e[i]) r = (r * x) % mm;
            x = (x * x) % mm;
        end
        return W2'(r);
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requester drivers: hold request until the accept pulse is seen.
    always @(negedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (rq.req_ready[i]) begin
                pending[i] = 1'b0;
                rr_cnt[i]  = rr_cnt[i] + 1;
            end
            rq.req_valid[i]                 = pending[i];
            rq.req_base[i*W2 +: W2]         = op_base[i];
            rq.req_modulo[i*W2 +: W2]       = op_mod[i];
            rq.req_exponent[i*W2 +: W2]     = op_exp[i];
        end
    end

    // Response side: decide ready, and score every response that will be taken.
    always @(negedge clk) begin
        logic [NREQ-1:0] ack;
        exp_t e;
        ack = auto_ack ? rq.resp_valid : man_ready;
        if (reset_n) begin
            for (int i = 0; i < NREQ; i++) begin
                if (rq.resp_valid[i] && ack[i]) begin
                    if (sb.size() == 0) begin
                        check_eq("unexpected_resp", 64'(i), 64'hFF);
                    end else begin
                        e = sb.pop_front();
                        check_eq("resp_id", 64'(i), 64'(e.id));
                        check_eq("resp_result", 64'(rq.resp_result), 64'(e.result));
                        check_eq("resp_err", 64'(rq.resp_err), 64'(e.err));
                    end
                end
            end
        end
        rq.resp_ready = ack;
    end

    // Behavioural engine: result after ENG_LAT cycles unless hung.
    always @(negedge clk) begin
        static int cnt = 0;
        static logic run = 1'b0;
        eng_finish = 1'b0;
        if (!reset_n) begin
            run = 1'b0;
        end else if (eng_load) begin
            eng_result = ref_modexp(eng_base, eng_exponent, eng_modulo);
            cnt        = ENG_LAT;
            run        = 1'b1;
            load_cnt   = load_cnt + 1;
        end else if (run) begin
            cnt = cnt - 1;
            if (cnt == 0) begin
                run        = 1'b0;
                eng_finish = !hang;
            end
        end
        if (inject_finish) begin
            eng_finish    = 1'b1;
            inject_finish = 1'b0;
        end
    end

    task automatic submit(input int id, input logic [W2-1:0] b, input logic [W2-1:0] m,
                          input logic [W2-1:0] e, input logic [W2-1:0] res, input logic err);
        exp_t x;
        op_base[id] = b;
        op_mod[id]  = m;
        op_exp[id]  = e;
        x.id = 2'(id); x.result = res; x.err = err;
        sb.push_back(x);
        pending[id] = 1'b1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while ((sb.size() != 0 || pending != '0 || busy) && n < 2000) begin
            n++;
            @(negedge clk);
        end
        check_eq(tag, 64'(n < 2000), 64'd1);
    endtask

    task automatic wait_sig(input string tag, input int which);
        int n = 0;
        @(negedge clk);
        while (n < 500 && !((which == 0 && eng_load) || (which == 1 && rq.resp_valid[0])
                            || (which == 2 && rq.req_ready[1]))) begin
            n++;
            @(negedge clk);
        end
        check_eq(tag, 64'(n < 500), 64'd1);
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
        check_eq({tag, "_load"}, 64'(eng_load), 64'd0);
        check_eq({tag, "_rdy"}, 64'(rq.req_ready), 64'd0);
        check_eq({tag, "_rv"}, 64'(rq.resp_valid), 64'd0);
        check_eq({tag, "_res"}, 64'({rq.resp_err, rq.resp_result}), 64'd0);
        check_eq({tag, "_ops"}, 64'(eng_base | eng_modulo | eng_exponent), 64'd0);
    endtask

    initial begin
        int n, l0;
        for (int i = 0; i < NREQ; i++) begin
            op_base[i] = '0; op_mod[i] = '0; op_exp[i] = '0; rr_cnt[i] = 0;
        end
        rq.req_valid = '0; rq.req_base = '0; rq.req_modulo = '0; rq.req_exponent = '0;
        rq.resp_ready = '0;
        eng_finish = 1'b0; eng_result = '0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_quiet("reset");
        reset_n = 1'b1;

        // Single job through the engine: 4^13 mod 497.
        submit(0, 32'd4, 32'd497, 32'd13, 32'd445, 1'b0);
        wait_idle("single_done");
        check_eq("single_rdy_pulses", 64'(rr_cnt[0]), 64'd1);
        check_eq("single_busy_low", 64'(busy), 64'd0);

        // Contention at reset release, then immediate re-request by requester 0.
        reset_n = 1'b0;
        @(negedge clk);
        submit(0, 32'd3, 32'd7, 32'd0, 32'd1, 1'b0);
        submit(1, 32'd7, 32'd561, 32'd560, 32'd1, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_sig("cont_first_resp", 1);
        submit(0, 32'd5, 32'd13, 32'd3, 32'd8, 1'b0);
        wait_idle("cont_done");

        // Zero modulus: answered without touching the engine.
        l0 = load_cnt;
        submit(1, 32'd9, 32'd0, 32'd5, 32'd0, 1'b1);
        wait_sig("zm_accept", 2);
        check_eq("zm_resp_with_accept", 64'(rq.resp_valid), 64'd2);
        wait_idle("zm_done");
        check_eq("zm_no_load", 64'(load_cnt), 64'(l0));

        // Engine hang: watchdog after exactly TMO RUN cycles.
        hang = 1'b1;
        submit(0, 32'd2, 32'd11, 32'd3, 32'd0, 1'b1);
        wait_sig("tmo_load", 0);
        n = 0;
        @(negedge clk);
        while (!rq.resp_valid[0] && n < 500) begin
            n++;
            @(negedge clk);
        end
        check_eq("tmo_run_cycles", 64'(n), 64'(TMO));
        wait_idle("tmo_done");
        hang = 1'b0;
        submit(0, 32'd2, 32'd11, 32'd3, 32'd8, 1'b0);
        wait_idle("after_tmo_done");

        // Backpressure with stray finish and non-owner ready.
        auto_ack  = 1'b0;
        man_ready = 2'b10;
        submit(0, 32'd3, 32'd10, 32'd4, 32'd1, 1'b0);
        wait_sig("bp_resp", 1);
        submit(1, 32'd2, 32'd7, 32'd5, 32'd4, 1'b0);
        for (int c = 0; c < 20; c++) begin
            if (c == 5) inject_finish = 1'b1;
            check_eq("bp_valid", 64'(rq.resp_valid), 64'd1);
            check_eq("bp_result", 64'({rq.resp_err, rq.resp_result}), 64'd1);
            check_eq("bp_no_accept", 64'(rq.req_ready), 64'd0);
            @(negedge clk);
        end
        auto_ack = 1'b1;
        wait_idle("bp_done");

        // Asynchronous reset in the middle of RUN.
        submit(0, 32'd3, 32'd7, 32'd5, 32'd0, 1'b0);
        void'(sb.pop_back());
        wait_sig("rst_load", 0);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check_quiet("midrun_reset");
        @(negedge clk);
        submit(0, 32'd2, 32'd5, 32'd3, 32'd3, 1'b0);
        submit(1, 32'd6, 32'd7, 32'd2, 32'd1, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_idle("post_reset_done");
        check_eq("sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/modexp_scheduler.md
Name: modexp_scheduler

Overview:
- Shares one modular-exponentiation engine between NUM_REQ requesters, such as the tag-side encrypt and reader-side decrypt paths.
- Arbitrates requests round-robin and latches the winner's operands.
- Sequences the engine's load/run/finish protocol, guards against a zero modulus and engine hang, and returns the result to the owning requester over a valid/ready handshake.
- Sits between the RFID protocol logic and the single engine instance.

Parameters:
- WORDSIZE, 16, half operand width; all operands and results are W2 = 2*WORDSIZE bits.
- NUM_REQ, 2, number of requesters (>=2).
- TIMEOUT_CYCLES, 1024, maximum RUN cycles before a job is abandoned; counter width is $clog2(TIMEOUT_CYCLES)+1.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester job request.
- req_ready  out  NUM_REQ  one-cycle accept pulse to the granted requester.
- req_base  in  NUM_REQ*W2  flattened; slice i = [i*W2 +: W2].
- req_modulo  in  NUM_REQ*W2  flattened, same slicing.
- req_exponent  in  NUM_REQ*W2  flattened, same slicing.
- resp_valid  out  NUM_REQ  result available to requester i; held until accepted.
- resp_ready  in  NUM_REQ  requester i accepts the response.
- resp_result  out  W2  result, shared bus; meaningful only with resp_valid.
- resp_err  out  1  1 = modulo zero or timeout; resp_result is 0 in that case.
- busy  out  1  high whenever state != IDLE.
- eng_load  out  1  drives the engine's synchronous load/reset input.
- eng_base, eng_modulo, eng_exponent  out  W2 each  latched operands, stable from LOAD until the next accept.
- eng_finish  in  1  engine completion, a one-cycle pulse.
- eng_result  in  W2  engine result, valid while eng_finish is high.

Behaviour:
- Reset (reset_n low, async):
  - State = IDLE; every output = 0.
  - last_grant = NUM_REQ-1, so requester 0 has first priority.
  - Latched operands = 0; timer = 0.
- States: IDLE, LOAD, RUN, RESP.
- IDLE:
  - If any req_valid, select the first set bit searching from last_grant+1, wrapping.
  - Pulse req_ready[sel] for that cycle and record owner = sel.
  - If req_modulo slice == 0: set resp_err=1, resp_result=0, go to RESP; the engine is not touched.
  - Otherwise latch the three operands into the eng_* outputs and go to LOAD.
- LOAD:
  - eng_load=1 for exactly one cycle; clear the timer; go to RUN.
- RUN:
  - eng_load=0; the timer increments every cycle.
  - eng_finish=1: capture eng_result into resp_result, resp_err=0, go to RESP.
  - Otherwise, when timer == TIMEOUT_CYCLES-1: resp_err=1, resp_result=0, go to RESP. The engine is left running; the next LOAD reinitialises it.
  - eng_finish and timeout in the same cycle: finish wins.
  - eng_finish is ignored in every state other than RUN.
- RESP:
  - resp_valid[owner]=1; all other resp_valid bits stay 0.
  - resp_result and resp_err are held stable.
  - When resp_ready[owner]=1: drop resp_valid that cycle (registered), set last_grant=owner, go to IDLE.
  - resp_ready on non-owner bits is ignored.
- Latency:
  - Accept in cycle N, eng_load in N+1, RUN from N+2.
  - resp_valid rises the cycle after eng_finish.
  - Zero-modulo error: resp_valid in N+1.
- Request rules:
  - No new request is accepted while busy; req_valid may stay high.
  - Operands need only be valid in the accept cycle.
  - A requester may re-request immediately after its response. Round-robin then prefers any other pending requester.
- Reset mid-operation: abort the job, outputs to their reset values, no response issued. The engine's state is irrelevant because the next LOAD reinitialises it.
- All outputs are registered; no combinational path from req_* to eng_*.

Decomposition:
- Shared package rsa_pkg holds:
  - the state encoding localparams (IDLE/LOAD/RUN/RESP);
  - the default WORDSIZE;
  - a default TIMEOUT_CYCLES sized for a 2*WORDSIZE-bit exponent at the engine's per-bit latency.
- One sub-module, rr_arbiter (NUM_REQ): inputs are the request vector and last_grant; outputs are a one-hot grant and its index. It is purely combinational; the grant pointer register stays in modexp_scheduler.

Test Plan:
- Single job: req0 base=4, modulo=497, exponent=13, real engine -> one req_ready[0] pulse; resp_valid[0] with resp_result=445, resp_err=0; busy low after ack.
- Back-to-back contention: req0 and req1 both valid at reset release, req0 (3,7,0), req1 (7,561,560) -> req0 granted first with result 1, then req1 with result 1. Re-assert req0 immediately -> req1 already served, req0 granted next.
- Zero modulus: req1 modulo=0 -> req_ready[1] pulse, resp_valid[1] next cycle, resp_err=1, result 0, eng_load never asserted.
- Timeout: TIMEOUT_CYCLES=64, engine stub never raises finish -> resp_valid[0] with err=1 exactly 64 RUN cycles after LOAD. A subsequent job with a working stub completes normally.
- Response backpressure: hold resp_ready=0 for 20 cycles -> resp_valid, result and err stable, no new req_ready despite req1 pending. A stray eng_finish pulse during RESP is ignored.
- Reset mid-RUN: drop reset_n asynchronously -> all outputs 0 immediately, no response. After release, requester 0 wins first.
